// File: rtl/strided_addr_gen.sv
// Strided address generator feeding a 4-wide packed-line FIFO.
// Optional stall counter output: define STRIDED_ADDR_GEN_STALL_CNT_EN.
module strided_addr_gen #(
  parameter int LINE  = 18,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LINE-1:0]  cmd_base,
  input  logic [LINE-1:0]  cmd_stride,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             full_soon,
  output logic             we,
  output logic [1:0]       we_count,
  output logic [LINE-1:0]  dat_w_1,
  output logic [LINE-1:0]  dat_w_2,
  output logic [LINE-1:0]  dat_w_3,
  output logic [LINE-1:0]  dat_w_4,
  output logic             busy,
`ifdef STRIDED_ADDR_GEN_STALL_CNT_EN
  output logic             done,
  output logic [31:0]      stall_cycles
`else
  output logic             done
`endif
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LINE-1:0]  next_addr;
  logic [LINE-1:0]  stride;
  logic [CNT_W-1:0] remaining;

  logic             accept;
  logic             issue;
  logic             last;
  logic [2:0]       n;
  logic [LINE-1:0]  stride2;
  logic [LINE-1:0]  stride3;
  logic [LINE-1:0]  stride4;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);

  assign stride2 = stride << 1;
  assign stride3 = stride2 + stride;
  assign stride4 = stride << 2;

  always_comb begin
    n = 3'd4;
    if (remaining < CNT_W'(4))
      n = remaining[2:0];
  end

  assign accept = (state == IDLE) && cmd_valid;
  assign issue  = (state == RUN) && !full_soon;
  // The issuing cycle that drains the command also ends it.
  assign last   = issue && (remaining <= CNT_W'(4));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && cmd_count != '0)
              state_nxt = RUN;
      RUN:  if (last)
              state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      next_addr <= '0;
      stride    <= '0;
      remaining <= '0;
      we        <= 1'b0;
      we_count  <= 2'd0;
      dat_w_1   <= '0;
      dat_w_2   <= '0;
      dat_w_3   <= '0;
      dat_w_4   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      we    <= issue;
      done  <= (accept && cmd_count == '0)
             || last;
      if (accept) begin
        next_addr <= cmd_base;
        stride    <= cmd_stride;
        remaining <= cmd_count;
      end
      if (issue) begin
        we_count  <= 2'(n - 3'd1);
        dat_w_4   <= next_addr;
        dat_w_3   <= next_addr + stride;
        dat_w_2   <= next_addr + stride2;
        dat_w_1   <= next_addr + stride3;
        next_addr <= next_addr + stride4;
        remaining <= remaining - CNT_W'(n);
      end
    end
  end

`ifdef STRIDED_ADDR_GEN_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (state == RUN && full_soon
             && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_strided_addr_gen.sv
// Bench for strided_addr_gen: address-queue model plus directed checks.
// Compile with STRIDED_ADDR_GEN_STALL_CNT_EN to also check the stall counter.
module tb_strided_addr_gen;
  localparam int LINE  = 18;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LINE-1:0]  cmd_base;
  logic [LINE-1:0]  cmd_stride;
  logic [CNT_W-1:0] cmd_count;
  logic             full_soon;
  logic             we;
  logic [1:0]       we_count;
  logic [LINE-1:0]  dat_w_1;
  logic [LINE-1:0]  dat_w_2;
  logic [LINE-1:0]  dat_w_3;
  logic [LINE-1:0]  dat_w_4;
  logic             busy;
  logic             done;
`ifdef STRIDED_ADDR_GEN_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  strided_addr_gen #(.LINE(LINE), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_base(cmd_base),
    .cmd_stride(cmd_stride),
    .cmd_count(cmd_count),
    .full_soon(full_soon),
    .we(we),
    .we_count(we_count),
    .dat_w_1(dat_w_1),
    .dat_w_2(dat_w_2),
    .dat_w_3(dat_w_3),
    .dat_w_4(dat_w_4),
    .busy(busy),
`ifdef STRIDED_ADDR_GEN_STALL_CNT_EN
    .done(done),
    .stall_cycles(stall_cycles)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int              c;
    logic [1:0]      n;
    logic [LINE-1:0] d4;
    logic [LINE-1:0] d3;
    logic [LINE-1:0] d2;
    logic [LINE-1:0] d1;
  } wr_t;

  int              cyc = 0;
  int              n_chk = 0;
  int              n_fail = 0;
  logic [LINE-1:0] exp_q[$];
  wr_t             wlog[$];
  int              done_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Model: every accepted command appends its full address list; each
  // write must consume exactly its valid slots, oldest first.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (we) begin
        wr_t w;
        w.c = cyc; w.n = we_count;
        w.d4 = dat_w_4; w.d3 = dat_w_3;
        w.d2 = dat_w_2; w.d1 = dat_w_1;
        wlog.push_back(w);
        for (int k = 0; k <= int'(we_count); k++) begin
          logic [LINE-1:0] s;
          s = (k == 0) ? dat_w_4 : (k == 1) ? dat_w_3 :
              (k == 2) ? dat_w_2 : dat_w_1;
          if (exp_q.size() == 0)
            chk("unexpected_write", 64'(s), 64'hdead);
          else
            chk("write_addr", 64'(s), 64'(exp_q.pop_front()));
        end
      end
      if (done) begin
        done_log.push_back(cyc);
        chk("done_drained", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic send(input logic [LINE-1:0] b,
                      input logic [LINE-1:0] s,
                      input logic [CNT_W-1:0] c,
                      output int t);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (i == 100) chk("ready_timeout", 64'd0, 64'd1);
    cmd_base = b; cmd_stride = s; cmd_count = c;
    cmd_valid = 1'b1;
    t = cyc;
    for (int k = 0; k < int'(c); k++)
      exp_q.push_back(LINE'(b + LINE'(k) * s));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 300) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_we();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (we) break;
    end
    if (i == 50) chk("we_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, w0, d0;
    reset = 1'b1; cmd_valid = 1'b0; full_soon = 1'b0;
    cmd_base = '0; cmd_stride = '0; cmd_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_we_count", 64'(we_count), 64'd0);
    chk("rst_dat", 64'({dat_w_1, dat_w_2, dat_w_3, dat_w_4}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    #1 reset = 1'b0;

    // base 0x100, stride 1, count 10
    w0 = wlog.size();
    send(18'h100, 18'h1, 16'd10, t);
    wait_done();
    chk("t1_nwr", 64'(wlog.size() - w0), 64'd3);
    if (wlog.size() - w0 == 3) begin
      chk("t1_c0", 64'(wlog[w0].c), 64'(t + 2));
      chk("t1_c2", 64'(wlog[w0+2].c), 64'(t + 4));
      chk("t1_n0", 64'(wlog[w0].n), 64'd3);
      chk("t1_n1", 64'(wlog[w0+1].n), 64'd3);
      chk("t1_n2", 64'(wlog[w0+2].n), 64'd1);
      chk("t1_a0", 64'(wlog[w0].d4), 64'h100);
      chk("t1_a1", 64'(wlog[w0+1].d4), 64'h104);
      chk("t1_a2", 64'(wlog[w0+2].d4), 64'h108);
      chk("t1_last_d3", 64'(wlog[w0+2].d3), 64'h109);
      chk("t1_done_cyc", 64'(done_log[$]), 64'(t + 4));
    end

    // count 0
    w0 = wlog.size(); d0 = done_log.size();
    send(18'h55, 18'h3, 16'd0, t);
    @(negedge clk);
    chk("t2_ready", 64'(cmd_ready), 64'd1);
    chk("t2_done", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    chk("t2_ndone", 64'(done_log.size() - d0), 64'd1);
    chk("t2_nwr", 64'(wlog.size() - w0), 64'd0);

    // wrap-around at 2^18
    w0 = wlog.size();
    send(18'h3FFFE, 18'h1, 16'd4, t);
    wait_done();
    chk("t3_nwr", 64'(wlog.size() - w0), 64'd1);
    if (wlog.size() - w0 == 1) begin
      chk("t3_n", 64'(wlog[w0].n), 64'd3);
      chk("t3_d4", 64'(wlog[w0].d4), 64'h3FFFE);
      chk("t3_d3", 64'(wlog[w0].d3), 64'h3FFFF);
      chk("t3_d2", 64'(wlog[w0].d2), 64'h00000);
      chk("t3_d1", 64'(wlog[w0].d1), 64'h00001);
    end

    // negative stride
    w0 = wlog.size();
    send(18'h40, 18'h3FFFC, 16'd5, t);
    wait_done();
    chk("t4_nwr", 64'(wlog.size() - w0), 64'd2);
    if (wlog.size() - w0 == 2) begin
      chk("t4_n0", 64'(wlog[w0].n), 64'd3);
      chk("t4_d4", 64'(wlog[w0].d4), 64'h40);
      chk("t4_d3", 64'(wlog[w0].d3), 64'h3C);
      chk("t4_d2", 64'(wlog[w0].d2), 64'h38);
      chk("t4_d1", 64'(wlog[w0].d1), 64'h34);
      chk("t4_n1", 64'(wlog[w0+1].n), 64'd0);
      chk("t4_b_d4", 64'(wlog[w0+1].d4), 64'h30);
    end

    // stall for 3 cycles after the first write
    w0 = wlog.size();
    send(18'h1000, 18'h10, 16'd12, t);
    wait_we();
    full_soon = 1'b1;
    repeat (3) @(posedge clk);
    #1 full_soon = 1'b0;
    wait_done();
    chk("t5_nwr", 64'(wlog.size() - w0), 64'd3);
    if (wlog.size() - w0 == 3) begin
      chk("t5_c0", 64'(wlog[w0].c), 64'(t + 2));
      chk("t5_c1", 64'(wlog[w0+1].c), 64'(t + 6));
      chk("t5_c2", 64'(wlog[w0+2].c), 64'(t + 7));
      chk("t5_a1", 64'(wlog[w0+1].d4), 64'h1040);
    end
`ifdef STRIDED_ADDR_GEN_STALL_CNT_EN
    chk("t5_stall", 64'(stall_cycles), 64'd3);
`endif

    // reset in the cycle after the first write
    send(18'h200, 18'h1, 16'd100, t);
    wait_we();
    d0 = done_log.size();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_we", 64'(we), 64'd0);
    chk("t6_ready", 64'(cmd_ready), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    repeat (5) @(negedge clk);
    chk("t6_nodone", 64'(done_log.size() - d0), 64'd0);
    w0 = wlog.size();
    send(18'h300, 18'h2, 16'd3, t);
    wait_done();
    chk("t6_nwr", 64'(wlog.size() - w0), 64'd1);
    if (wlog.size() - w0 == 1) begin
      chk("t6_n", 64'(wlog[w0].n), 64'd2);
      chk("t6_d4", 64'(wlog[w0].d4), 64'h300);
      chk("t6_d2", 64'(wlog[w0].d2), 64'h304);
    end

    repeat (3) @(negedge clk);
    chk("final_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
